// File: rtl/noc_params.sv
// Purpose: shared router parameters and the port_t encoding used across the router.
// Latency: n/a (types and constants only).
// Backpressure: n/a; port_t's value doubles as the output/crossbar index.
package noc_params;

    localparam int VC_NUM    = 2;
    localparam int VC_SIZE   = $clog2(VC_NUM);
    localparam int PORT_NUM  = 5;
    localparam int PORT_SIZE = $clog2(PORT_NUM);

    typedef enum logic [PORT_SIZE-1:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        SOUTH = 3'd2,
        WEST  = 3'd3,
        EAST  = 3'd4
    } port_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Purpose: N-way round-robin arbiter; grants the first request at or after its pointer.
// Latency: grant is combinational in the request cycle; pointer moves at the next posedge.
// Backpressure: pointer only advances (past the grant) when update_i accepts the grant.
// Ports: clk, rst (sync, active-high) | request_i[N], update_i |
//        grant_o (one-hot), grant_idx_o, valid_o (any request granted).
module round_robin_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  request_i,
    input  logic          update_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          valid_o
);

    logic [IW-1:0] ptr;
    // One extra bit so ptr + offset never overflows before the wrap compare.
    logic [IW:0]   scan_sum;
    logic [IW-1:0] scan_idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int i = 0; i < N; i++) begin
            scan_sum = {1'b0, ptr} + (IW+1)'(i);
            if (scan_sum >= (IW+1)'(N)) begin
                scan_sum = scan_sum - (IW+1)'(N);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!valid_o && request_i[scan_idx]) begin
                valid_o           = 1'b1;
                grant_o[scan_idx] = 1'b1;
                grant_idx_o       = scan_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (update_i && valid_o) begin
            if (grant_idx_o == IW'(N-1)) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx_o + IW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Purpose: separable input-first switch allocator (RR VC pick per input, then RR input pick per output).
// Latency: 0 cycles request->grant; round-robin pointers take effect the following cycle.
// Backpressure: VCs whose downstream on_off flag is low are masked in the same cycle; losers retry.
// Ports: clk, rst (sync, active-high) |
//        request_i/out_port_i/downstream_vc_i per input VC, on_off_i per output VC |
//        valid_sel_o/vc_sel_o per input, xb_sel_o/xb_valid_o per output.
module switch_allocator
    import noc_params::*;
(
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]              request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off_i,
    output logic  [PORT_NUM-1:0]                          valid_sel_o,
    output logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel_o,
    output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xb_sel_o,
    output logic  [PORT_NUM-1:0]                          xb_valid_o
);

    // Stage 1 (per input p)
    logic [PORT_NUM-1:0][VC_NUM-1:0]    eligible;
    logic [PORT_NUM-1:0][VC_NUM-1:0]    in_gnt;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   cand_vc;
    logic [PORT_NUM-1:0]                cand_vld;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] cand_port;

    // Stage 2 (indexed [output][input])
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_req;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_gnt;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] out_idx;
    logic [PORT_NUM-1:0]                out_vld;
    logic [PORT_NUM-1:0]                in_won;

    // A VC may compete only if the downstream VC it was allocated can accept a flit.
    always_comb begin
        eligible = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                eligible[p][v] = request_i[p][v] &
                                 on_off_i[out_port_i[p][v]][downstream_vc_i[p][v]];
            end
        end
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : gen_in_arb
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .clk         (clk),
            .rst         (rst),
            .request_i   (eligible[p]),
            .update_i    (valid_sel_o[p]),
            .grant_o     (in_gnt[p]),
            .grant_idx_o (cand_vc[p]),
            .valid_o     (cand_vld[p])
        );
    end

    // Target output of each input's candidate, muxed by the one-hot VC grant.
    always_comb begin
        cand_port = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (in_gnt[p][v]) begin
                    cand_port[p] = out_port_i[p][v];
                end
            end
        end
    end

    // Decode each valid candidate into a request at its target output.
    always_comb begin
        out_req = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                out_req[o][p] = cand_vld[p] && (cand_port[p] == PORT_SIZE'(o));
            end
        end
    end

    for (genvar o = 0; o < PORT_NUM; o++) begin : gen_out_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk         (clk),
            .rst         (rst),
            .request_i   (out_req[o]),
            .update_i    (xb_valid_o[o]),
            .grant_o     (out_gnt[o]),
            .grant_idx_o (out_idx[o]),
            .valid_o     (out_vld[o])
        );
    end

    // Each input has one candidate, hence at most one output can grant it.
    always_comb begin
        in_won = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int o = 0; o < PORT_NUM; o++) begin
                in_won[p] = in_won[p] | out_gnt[o][p];
            end
        end
    end

    // Outputs are forced idle while rst is high, so no pointer moves on a reset cycle either.
    always_comb begin
        valid_sel_o = '0;
        vc_sel_o    = '0;
        xb_sel_o    = '0;
        xb_valid_o  = '0;
        if (!rst) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                if (in_won[p]) begin
                    valid_sel_o[p] = 1'b1;
                    vc_sel_o[p]    = cand_vc[p];
                end
            end
            for (int o = 0; o < PORT_NUM; o++) begin
                if (out_vld[o]) begin
                    xb_valid_o[o] = 1'b1;
                    xb_sel_o[o]   = out_idx[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
module tb_switch_allocator;
    import noc_params::*;

    typedef struct packed {
        logic [PORT_NUM-1:0]                valid_sel;
        logic [PORT_NUM-1:0][VC_SIZE-1:0]   vc_sel;
        logic [PORT_NUM-1:0][PORT_SIZE-1:0] xb_sel;
        logic [PORT_NUM-1:0]                xb_valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;
    logic  [PORT_NUM-1:0]                          valid_sel;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           xb_sel;
    logic  [PORT_NUM-1:0]                          xb_valid;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    int   m_in_ptr[PORT_NUM];
    int   m_out_ptr[PORT_NUM];

    always #5 clk = ~clk;

    switch_allocator dut (
        .clk             (clk),
        .rst             (rst),
        .request_i       (request),
        .out_port_i      (out_port),
        .downstream_vc_i (dvc),
        .on_off_i        (on_off),
        .valid_sel_o     (valid_sel),
        .vc_sel_o        (vc_sel),
        .xb_sel_o        (xb_sel),
        .xb_valid_o      (xb_valid)
    );

    // Reference model: separable allocator evaluated from the model's own pointers.
    function automatic exp_t model_eval();
        exp_t e;
        int   cand[PORT_NUM];
        bit   cv[PORT_NUM];
        e = '0;
        if (rst) return e;
        for (int p = 0; p < PORT_NUM; p++) begin
            cv[p]   = 1'b0;
            cand[p] = 0;
            for (int i = 0; i < VC_NUM; i++) begin
                int v;
                v = (m_in_ptr[p] + i) % VC_NUM;
                if (!cv[p] && request[p][v] && on_off[int'(out_port[p][v])][int'(dvc[p][v])]) begin
                    cv[p]   = 1'b1;
                    cand[p] = v;
                end
            end
        end
        for (int o = 0; o < PORT_NUM; o++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                int p;
                p = (m_out_ptr[o] + i) % PORT_NUM;
                if (!e.xb_valid[o] && cv[p] && int'(out_port[p][cand[p]]) == o) begin
                    e.xb_valid[o]  = 1'b1;
                    e.xb_sel[o]    = PORT_SIZE'(p);
                    e.valid_sel[p] = 1'b1;
                    e.vc_sel[p]    = VC_SIZE'(cand[p]);
                end
            end
        end
        return e;
    endfunction

    task automatic push_expect();
        exp_q.push_back(model_eval());
    endtask

    // Advance model pointers as the DUT will at the coming posedge.
    task automatic commit(input exp_t e);
        for (int i = 0; i < PORT_NUM; i++) begin
            if (rst) begin
                m_in_ptr[i]  = 0;
                m_out_ptr[i] = 0;
            end else begin
                if (e.valid_sel[i]) m_in_ptr[i] = (int'(e.vc_sel[i]) + 1) % VC_NUM;
                if (e.xb_valid[i])  m_out_ptr[i] = (int'(e.xb_sel[i]) + 1) % PORT_NUM;
            end
        end
    endtask

    task automatic clear_inputs();
        request = '0;
        dvc     = '0;
        on_off  = '1;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++)
                out_port[p][v] = LOCAL;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < PORT_NUM; i++) begin
            m_in_ptr[i]  = 0;
            m_out_ptr[i] = 0;
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        exp_t e, got;
        request = '1;
        for (int p = 0; p < PORT_NUM; p++)
            for (int v = 0; v < VC_NUM; v++)
                out_port[p][v] = port_t'((p + v) % PORT_NUM);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) rst = 1'b0;
            push_expect();
            @(negedge clk);
            e = exp_q.pop_front();
            got = {valid_sel, vc_sel, xb_sel, xb_valid};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL reset_model cyc=%0d got=%h exp=%h", c, got, e);
            end
            if (c < 2) begin
                total++;
                if (got !== exp_t'(0)) begin
                    bad++;
                    $display("FAIL reset_idle cyc=%0d got=%h exp=0", c, got);
                end
            end else if (c == 2) begin
                // Pointers at 0: every input offers VC0, which routes to output p.
                total++;
                if (valid_sel !== 5'h1f || xb_valid !== 5'h1f || vc_sel !== '0 ||
                    xb_sel !== {3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
                    bad++;
                    $display("FAIL reset_first_grant got vs=%h vc=%h xs=%h xv=%h exp vs=1f vc=0 xs=4688 xv=1f",
                             valid_sel, vc_sel, xb_sel, xb_valid);
                end
            end
            commit(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single();
        exp_t e, got;
        do_reset();
        request[1][1]  = 1'b1;
        out_port[1][1] = EAST;
        push_expect();
        @(negedge clk);
        e = exp_q.pop_front();
        got = {valid_sel, vc_sel, xb_sel, xb_valid};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL single_model got=%h exp=%h", got, e);
        end
        total++;
        if (valid_sel !== 5'b00010 || vc_sel[1] !== 1'b1 || xb_sel[EAST] !== 3'd1 || xb_valid !== 5'b10000) begin
            bad++;
            $display("FAIL single_grant got vs=%b vc1=%b xs_east=%0d xv=%b exp vs=00010 vc1=1 xs_east=1 xv=10000",
                     valid_sel, vc_sel[1], xb_sel[EAST], xb_valid);
        end
        commit(e);
        @(posedge clk); #1;
    endtask

    task automatic test_rr_output();
        exp_t e, got;
        int   exp_sel[4] = '{0, 2, 0, 2};
        do_reset();
        request[0][0] = 1'b1;
        request[2][0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            push_expect();
            @(negedge clk);
            e = exp_q.pop_front();
            got = {valid_sel, vc_sel, xb_sel, xb_valid};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL rr_output_model cyc=%0d got=%h exp=%h", c, got, e);
            end
            total++;
            if (int'(xb_sel[LOCAL]) != exp_sel[c] || xb_valid !== 5'b00001 ||
                valid_sel !== ((c % 2 == 0) ? 5'b00001 : 5'b00100)) begin
                bad++;
                $display("FAIL rr_output cyc=%0d got xs_local=%0d vs=%b exp xs_local=%0d", c, xb_sel[LOCAL], valid_sel, exp_sel[c]);
            end
            commit(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rr_vc();
        exp_t e, got;
        do_reset();
        request[0]     = 2'b11;
        out_port[0][0] = NORTH;
        out_port[0][1] = SOUTH;
        for (int c = 0; c < 4; c++) begin
            push_expect();
            @(negedge clk);
            e = exp_q.pop_front();
            got = {valid_sel, vc_sel, xb_sel, xb_valid};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL rr_vc_model cyc=%0d got=%h exp=%h", c, got, e);
            end
            total++;
            if (int'(vc_sel[0]) != c % 2 || xb_valid !== ((c % 2 == 0) ? 5'b00010 : 5'b00100)) begin
                bad++;
                $display("FAIL rr_vc cyc=%0d got vc0=%0d xv=%b exp vc0=%0d", c, vc_sel[0], xb_valid, c % 2);
            end
            commit(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_on_off();
        exp_t e, got;
        do_reset();
        request[3][0]  = 1'b1;
        out_port[3][0] = WEST;
        dvc[3][0]      = 1'b1;
        on_off[WEST][1] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) on_off[WEST][1] = 1'b1;
            push_expect();
            @(negedge clk);
            e = exp_q.pop_front();
            got = {valid_sel, vc_sel, xb_sel, xb_valid};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL on_off_model cyc=%0d got=%h exp=%h", c, got, e);
            end
            total++;
            if (xb_valid !== ((c == 3) ? 5'b01000 : 5'b00000) ||
                valid_sel !== ((c == 3) ? 5'b01000 : 5'b00000)) begin
                bad++;
                $display("FAIL on_off cyc=%0d got xv=%b vs=%b exp both %b", c, xb_valid, valid_sel,
                         (c == 3) ? 5'b01000 : 5'b00000);
            end
            commit(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall();
        exp_t e, got;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin
                // Grant input 0 at EAST once so out_ptr[EAST] moves to 1.
                request[0][0]  = 1'b1;
                out_port[0][0] = EAST;
            end else if (c == 1) begin
                request        = '0;
                request[3]     = 2'b11;
                out_port[3][0] = EAST;
                out_port[3][1] = WEST;
                request[1][0]  = 1'b1;
                out_port[1][0] = EAST;
            end else begin
                request[1][0] = 1'b0;
            end
            push_expect();
            @(negedge clk);
            e = exp_q.pop_front();
            got = {valid_sel, vc_sel, xb_sel, xb_valid};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL stall_model cyc=%0d got=%h exp=%h", c, got, e);
            end
            if (c == 1) begin
                total++;
                if (valid_sel !== 5'b00010 || xb_sel[EAST] !== 3'd1 || xb_valid !== 5'b10000) begin
                    bad++;
                    $display("FAIL stall_loser got vs=%b xs_east=%0d xv=%b exp vs=00010 xs_east=1 xv=10000",
                             valid_sel, xb_sel[EAST], xb_valid);
                end
            end else if (c == 2) begin
                total++;
                if (valid_sel !== 5'b01000 || vc_sel[3] !== 1'b0 || xb_sel[EAST] !== 3'd3 || xb_valid !== 5'b10000) begin
                    bad++;
                    $display("FAIL stall_retry got vs=%b vc3=%0d xs_east=%0d xv=%b exp vs=01000 vc3=0 xs_east=3 xv=10000",
                             valid_sel, vc_sel[3], xb_sel[EAST], xb_valid);
                end
            end
            commit(e);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        exp_t e, got;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            for (int p = 0; p < PORT_NUM; p++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    request[p][v]  = ($urandom_range(0, 2) != 0);
                    out_port[p][v] = port_t'($urandom_range(0, PORT_NUM - 1));
                    dvc[p][v]      = VC_SIZE'($urandom_range(0, VC_NUM - 1));
                    on_off[p][v]   = ($urandom_range(0, 4) != 0);
                end
            end
            push_expect();
            @(negedge clk);
            e = exp_q.pop_front();
            got = {valid_sel, vc_sel, xb_sel, xb_valid};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL random cyc=%0d rst=%b got=%h exp=%h", c, rst, got, e);
            end
            commit(e);
            @(posedge clk); #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int i = 0; i < PORT_NUM; i++) begin
            m_in_ptr[i]  = 0;
            m_out_ptr[i] = 0;
        end
        @(posedge clk); #1;
        test_reset();
        test_single();
        test_rr_output();
        test_rr_vc();
        test_on_off();
        test_stall();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
